// File: rtl/jt12_comb_pkg.sv
// Shared definitions for the time-multiplexed jt12 comb section:
// FSM encoding, width helpers and delay-memory address composition.
package jt12_comb_pkg;

    typedef enum logic [1:0] {
        ST_CLR  = 2'd0,
        ST_IDLE = 2'd1,
        ST_RUN  = 2'd2
    } comb_state_e;

    // Ceiling log2 for width derivation (clog2(1) = 0).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((32'sd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Widths never collapse below one bit.
    function automatic int at_least_1(input int n);
        return (n < 1) ? 1 : n;
    endfunction

    // Dense word address for {ch, stage, tap}, so that CLR touches exactly
    // CH*S*M words even when the dimensions are not powers of two.
    function automatic int comb_addr(input int ch, input int stg, input int tap,
                                     input int stages, input int taps);
        return (ch * stages + stg) * taps + tap;
    endfunction

endpackage

// File: rtl/jt12_comb_ram.sv
// Delay memory for the comb section: one write port, one asynchronous read
// port, so a read and a write to the same word in one cycle return the old
// contents (read-before-write). No reset; the owner clears it word by word.
module jt12_comb_ram #(
    parameter int W     = 16,
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_r [DEPTH];

    assign rdata = mem_r[raddr];

    // Write port: commits one word per enabled clock.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/jt12_comb_tdm.sv
// Time-multiplexed CH-channel, S-stage comb (differentiator) with delay M.
// One subtractor and one delay memory are shared; each accepted sample walks
// through all stages, one per cen cycle, and leaves tagged with its channel.
// Optional feature macro: JT12_COMB_SAT_EN (saturating final stage).
module jt12_comb_tdm
    import jt12_comb_pkg::*;
#(
    parameter int  W  = 16,
    parameter int  M  = 1,
    parameter int  S  = 1,
    parameter int  CH = 2,
    localparam int CW = at_least_1(clog2(CH))
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cen,
    input  logic                in_valid,
    input  logic [CW-1:0]       in_ch,
    input  logic signed [W-1:0] snd_in,
    output logic                in_ready,
    output logic                out_valid,
    output logic [CW-1:0]       out_ch,
    output logic signed [W-1:0] snd_out
);

    localparam int NW = CH * S * M;
    localparam int AW = at_least_1(clog2(NW));
    localparam int SW = at_least_1(clog2(S));
    localparam int MW = at_least_1(clog2(M));
    localparam logic [CW:0]   CH_L   = (CW+1)'(CH);
    localparam logic [AW-1:0] LAST_W = AW'(NW - 1);
    localparam logic [SW-1:0] LAST_S = SW'(S - 1);
    localparam logic [MW-1:0] LAST_T = MW'(M - 1);

    comb_state_e   state_q,    state_d;
    logic [AW-1:0] clr_cnt_q,  clr_cnt_d;
    logic [W-1:0]  x_q,        x_d;
    logic [CW-1:0] ch_q,       ch_d;
    logic [SW-1:0] stg_q,      stg_d;
    logic [MW-1:0] ptr_q [CH];
    logic [MW-1:0] ptr_d [CH];
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [CW-1:0] out_ch_q,   out_ch_d;
    logic [W-1:0]  snd_out_q,  snd_out_d;

    logic          mem_we_s;
    logic [AW-1:0] mem_addr_s;
    logic [AW-1:0] run_addr_s;
    logic [W-1:0]  mem_wdata_s;
    logic [W-1:0]  mem_rdata_s;
    logic [W-1:0]  wrap_diff_s;
    logic [W-1:0]  final_s;

    // Saturate a W+1-bit difference into W bits.
    function automatic logic [W-1:0] sat_w(input logic [W:0] v);
        if (v[W] != v[W-1]) begin
            return v[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            return v[W-1:0];
        end
    endfunction

    jt12_comb_ram #(.W(W), .DEPTH(NW), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (mem_we_s & ~rst),
        .waddr (mem_addr_s),
        .wdata (mem_wdata_s),
        .raddr (mem_addr_s),
        .rdata (mem_rdata_s)
    );

    assign run_addr_s  = AW'(comb_addr(int'(ch_q), int'(stg_q), int'(ptr_q[ch_q]), S, M));
    assign wrap_diff_s = x_q - mem_rdata_s;

`ifdef JT12_COMB_SAT_EN
    logic [W:0] wide_diff_s;
    assign wide_diff_s = {x_q[W-1], x_q} - {mem_rdata_s[W-1], mem_rdata_s};
    assign final_s     = sat_w(wide_diff_s);
`else
    assign final_s     = wrap_diff_s;
`endif

    // Next-state logic: clear sweep, handshake and one stage per cen cycle.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        x_d         = x_q;
        ch_d        = ch_q;
        stg_d       = stg_q;
        ptr_d       = ptr_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        snd_out_d   = snd_out_q;
        mem_we_s    = 1'b0;
        mem_addr_s  = {AW{1'b0}};
        mem_wdata_s = {W{1'b0}};
        case (state_q)
            ST_CLR: begin
                // Runs at full clock rate regardless of cen.
                mem_we_s   = 1'b1;
                mem_addr_s = clr_cnt_q;
                if (clr_cnt_q == LAST_W) begin
                    state_d    = ST_IDLE;
                    in_ready_d = 1'b1;
                    clr_cnt_d  = {AW{1'b0}};
                end else begin
                    clr_cnt_d  = clr_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (cen) begin
                    out_valid_d = 1'b0;
                    if (in_valid && ({1'b0, in_ch} < CH_L)) begin
                        x_d        = snd_in;
                        ch_d       = in_ch;
                        stg_d      = {SW{1'b0}};
                        in_ready_d = 1'b0;
                        state_d    = ST_RUN;
                    end else begin
                        // Nothing offered, or an out-of-range channel that
                        // the handshake silently consumes.
                        state_d    = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cen) begin
                    mem_we_s    = 1'b1;
                    mem_addr_s  = run_addr_s;
                    mem_wdata_s = x_q;
                    if (stg_q == LAST_S) begin
                        snd_out_d   = final_s;
                        out_ch_d    = ch_q;
                        out_valid_d = 1'b1;
                        in_ready_d  = 1'b1;
                        state_d     = ST_IDLE;
                        if (ptr_q[ch_q] == LAST_T) begin
                            ptr_d[ch_q] = {MW{1'b0}};
                        end else begin
                            ptr_d[ch_q] = ptr_q[ch_q] + 1'b1;
                        end
                    end else begin
                        x_d   = wrap_diff_s;
                        stg_d = stg_q + 1'b1;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_CLR;
            end
        endcase
    end

    // State and output registers with synchronous reset into the clear sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_CLR;
            clr_cnt_q   <= {AW{1'b0}};
            x_q         <= {W{1'b0}};
            ch_q        <= {CW{1'b0}};
            stg_q       <= {SW{1'b0}};
            for (int i = 0; i < CH; i++) begin
                ptr_q[i] <= {MW{1'b0}};
            end
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_ch_q    <= {CW{1'b0}};
            snd_out_q   <= {W{1'b0}};
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            x_q         <= x_d;
            ch_q        <= ch_d;
            stg_q       <= stg_d;
            ptr_q       <= ptr_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            snd_out_q   <= snd_out_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign snd_out   = snd_out_q;

endmodule
